// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-port register file with two combinational read
// ports, one synchronous write port and a sequential sweep-clear engine.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a write in progress in IDLE is forwarded to any read port
//   that addresses the same register, in the same cycle. Forwarding is never
//   applied during a sweep-clear or to a hardwired-zero register 0.
//
// Handshake note: there is no valid/ready pairing here. write_enable is a
// single-cycle strobe sampled on the rising edge and only honoured in IDLE.
// clear_req is sampled on the rising edge in IDLE only. busy is high exactly
// while the sweep runs, and clear_done is a one-cycle pulse in the cycle that
// follows the edge which cleared the last register.
//
// state_dbg / idx_dbg expose the FSM state and sweep index for observation.

module regfile_multiport #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] dest_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    output logic [DATA_W-1:0] src1_data,
    output logic [DATA_W-1:0] src2_data,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    output logic              state_dbg,
    output logic [ADDR_W-1:0] idx_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic              clr_en;
    logic              dest_is_zero;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Register 0 is read-only zero when ZERO_REG is set.
    assign dest_is_zero = (ZERO_REG != 0) && (dest_reg == '0);

    // State register, sweep index and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: IDLE accepts writes and clear requests, CLEAR sweeps
    // one register per edge and ignores every request until it finishes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en = write_enable;
                if (clear_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Register array: write in IDLE, zero one entry per edge in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en && !dest_is_zero) begin
                regs[dest_reg] <= write_data;
            end
            if (clr_en) begin
                regs[idx_q] <= '0;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp_ok;
    assign byp_ok = (state_q == IDLE) && write_enable && !dest_is_zero;
`endif

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        src1_data = regs[src1];
        src2_data = regs[src2];
        if ((ZERO_REG != 0) && (src1 == '0)) begin
            src1_data = '0;
        end
        if ((ZERO_REG != 0) && (src2 == '0)) begin
            src2_data = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (byp_ok && (src1 == dest_reg)) begin
            src1_data = write_data;
        end
        if (byp_ok && (src2 == dest_reg)) begin
            src2_data = write_data;
        end
`endif
    end

    assign busy       = (state_q == CLEAR);
    assign clear_done = done_q;
    assign state_dbg  = state_q;
    assign idx_dbg    = idx_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed, table-driven bench for regfile_multiport.
// Three instances: default (8b x 4), ZERO_REG=1, and 16b x 8.

module tb_regfile_multiport;

    // ------------------------------------------------------------ clock/reset
    logic clk;
    logic reset_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------ default instance
    logic       write_enable;
    logic [1:0] dest_reg;
    logic [7:0] write_data;
    logic [1:0] src1, src2;
    logic [7:0] src1_data, src2_data;
    logic       clear_req, busy, clear_done, state_dbg;
    logic [1:0] idx_dbg;

    regfile_multiport #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(0)) dut (
        .clk(clk), .reset_n(reset_n), .write_enable(write_enable),
        .dest_reg(dest_reg), .write_data(write_data), .src1(src1), .src2(src2),
        .src1_data(src1_data), .src2_data(src2_data), .clear_req(clear_req),
        .busy(busy), .clear_done(clear_done), .state_dbg(state_dbg),
        .idx_dbg(idx_dbg)
    );

    // ----------------------------------------------------- ZERO_REG instance
    logic       z_we;
    logic [1:0] z_dest;
    logic [7:0] z_wdata;
    logic [1:0] z_src1, z_src2;
    logic [7:0] z_rd1, z_rd2;
    logic       z_clr, z_busy, z_done, z_state;
    logic [1:0] z_idx;

    regfile_multiport #(.DATA_W(8), .NUM_REGS(4), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset_n(reset_n), .write_enable(z_we),
        .dest_reg(z_dest), .write_data(z_wdata), .src1(z_src1), .src2(z_src2),
        .src1_data(z_rd1), .src2_data(z_rd2), .clear_req(z_clr),
        .busy(z_busy), .clear_done(z_done), .state_dbg(z_state),
        .idx_dbg(z_idx)
    );

    // --------------------------------------------------------- wide instance
    logic        w_we;
    logic [2:0]  w_dest;
    logic [15:0] w_wdata;
    logic [2:0]  w_src1, w_src2;
    logic [15:0] w_rd1, w_rd2;
    logic        w_clr, w_busy, w_done, w_state;
    logic [2:0]  w_idx;

    regfile_multiport #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(0)) dut_w (
        .clk(clk), .reset_n(reset_n), .write_enable(w_we),
        .dest_reg(w_dest), .write_data(w_wdata), .src1(w_src1), .src2(w_src2),
        .src1_data(w_rd1), .src2_data(w_rd2), .clear_req(w_clr),
        .busy(w_busy), .clear_done(w_done), .state_dbg(w_state),
        .idx_dbg(w_idx)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------- driver tasks
    task automatic drive(input logic we, input logic [1:0] d,
                         input logic [7:0] wd, input logic [1:0] a1,
                         input logic [1:0] a2, input logic clr);
        write_enable = we;
        dest_reg     = d;
        write_data   = wd;
        src1         = a1;
        src2         = a2;
        clear_req    = clr;
    endtask

    // Wait for the falling edge, then drive; reads are sampled 1 time unit on.
    task automatic cycle_drive(input logic we, input logic [1:0] d,
                               input logic [7:0] wd, input logic [1:0] a1,
                               input logic [1:0] a2, input logic clr);
        @(negedge clk);
        drive(we, d, wd, a1, a2, clr);
        #1;
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic       we;
        logic [1:0] dest;
        logic [7:0] wdata;
        logic [1:0] s1;
        logic [1:0] s2;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t vecs[8];

    // Clear-sweep expectations, one entry per cycle after the clear edge.
    logic       cs_clr  [8];
    logic       cs_we   [8];
    logic [1:0] cs_s1   [8];
    logic [1:0] cs_s2   [8];
    logic [7:0] cs_e1   [8];
    logic [7:0] cs_e2   [8];
    logic       cs_busy [8];
    logic       cs_done [8];

    initial begin
        // Expected pre-edge reads: values visible before each vector's edge.
        vecs[0] = '{1'b1, 2'd2, 8'hFF, 2'd0, 2'd3, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 2'd3, 8'h5A, 2'd2, 2'd0, 8'hFF, 8'h00};
        vecs[2] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 8'hFF, 8'h5A};
        vecs[3] = '{1'b1, 2'd0, 8'h11, 2'd1, 2'd2, 8'h00, 8'hFF};
        vecs[4] = '{1'b1, 2'd1, 8'h22, 2'd0, 2'd3, 8'h11, 8'h5A};
        vecs[5] = '{1'b1, 2'd2, 8'h33, 2'd0, 2'd1, 8'h11, 8'h22};
        vecs[6] = '{1'b1, 2'd3, 8'h44, 2'd2, 2'd1, 8'h33, 8'h22};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 8'h44, 8'h11};

        // Sweep from regs {11,22,33,44}; a reg2 write of 0x99 and a held
        // clear_req are offered during the first three CLEAR cycles.
        cs_clr  = '{1, 1, 1, 0, 0, 0, 0, 0};
        cs_we   = '{1, 1, 1, 0, 0, 0, 0, 0};
        cs_s1   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1};
        cs_s2   = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd2, 2'd3};
        cs_e1   = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cs_e2   = '{8'h44, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        cs_busy = '{1, 1, 1, 1, 0, 0, 0, 0};
        cs_done = '{0, 0, 0, 0, 1, 0, 0, 0};
    end

    // --------------------------------------------------------------- test
    initial begin : main
        int busy_cnt;
        int done_cnt;

        reset_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0);
        z_we = 0; z_dest = 0; z_wdata = 0; z_src1 = 0; z_src2 = 0; z_clr = 0;
        w_we = 0; w_dest = 0; w_wdata = 0; w_src1 = 0; w_src2 = 0; w_clr = 0;
        repeat (2) @(posedge clk);

        // Reset state: all registers zero, FSM idle.
        @(negedge clk);
        reset_n = 1'b1;
        src1 = 2'd0; src2 = 2'd1;
        #1;
        check("rst_rd0", 32'(src1_data), 32'h0);
        check("rst_rd1", 32'(src2_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(clear_done), 32'h0);
        check("rst_state", 32'(state_dbg), 32'h0);
        src1 = 2'd2; src2 = 2'd3;
        #1;
        check("rst_rd2", 32'(src1_data), 32'h0);
        check("rst_rd3", 32'(src2_data), 32'h0);

        // Table-driven writes/reads on the default instance.
        for (int i = 0; i < 8; i++) begin
            cycle_drive(vecs[i].we, vecs[i].dest, vecs[i].wdata,
                        vecs[i].s1, vecs[i].s2, 1'b0);
            exp_q.push_back(32'(vecs[i].e1));
            exp_q.push_back(32'(vecs[i].e2));
            check($sformatf("vec%0d_src1", i), 32'(src1_data), exp_q.pop_front());
            check($sformatf("vec%0d_src2", i), 32'(src2_data), exp_q.pop_front());
        end

        // Sweep-clear with a lost write and an ignored repeated clear_req.
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b1);
        check("clr_pre_busy", 32'(busy), 32'h0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cycle_drive(cs_we[i], 2'd2, 8'h99, cs_s1[i], cs_s2[i], cs_clr[i]);
            check($sformatf("clr_c%0d_busy", i), 32'(busy), 32'(cs_busy[i]));
            check($sformatf("clr_c%0d_done", i), 32'(clear_done), 32'(cs_done[i]));
            check($sformatf("clr_c%0d_src1", i), 32'(src1_data), 32'(cs_e1[i]));
            check($sformatf("clr_c%0d_src2", i), 32'(src2_data), 32'(cs_e2[i]));
            if (busy) busy_cnt++;
            if (clear_done) done_cnt++;
        end
        check("clr_busy_cycles", 32'(busy_cnt), 32'd4);
        check("clr_done_pulses", 32'(done_cnt), 32'd1);

        // Same-cycle forwarding versus old value.
        cycle_drive(1'b1, 2'd1, 8'h12, 2'd0, 2'd0, 1'b0);
        cycle_drive(1'b1, 2'd1, 8'h7E, 2'd1, 2'd1, 1'b0);
`ifdef REGFILE_BYPASS_EN
        check("byp_pre_edge", 32'(src1_data), 32'h7E);
`else
        check("byp_pre_edge", 32'(src1_data), 32'h12);
`endif
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd1, 2'd0, 1'b0);
        check("byp_post_edge", 32'(src1_data), 32'h7E);

        // Reset asserted two cycles into a sweep.
        cycle_drive(1'b1, 2'd3, 8'h44, 2'd0, 2'd0, 1'b0);
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b1);
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b0);
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd3, 2'd1, 1'b0);
        check("abort_pre_busy", 32'(busy), 32'h1);
        check("abort_pre_reg3", 32'(src1_data), 32'h44);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(clear_done), 32'h0);
        check("abort_reg3", 32'(src1_data), 32'h0);
        check("abort_reg1", 32'(src2_data), 32'h0);
        src1 = 2'd0; src2 = 2'd2;
        #1;
        check("abort_reg0", 32'(src1_data), 32'h0);
        check("abort_reg2", 32'(src2_data), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 2'd2, 8'hA5, 2'd3, 2'd0, 1'b0);
        cycle_drive(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0);
        check("post_rst_write", 32'(src1_data), 32'hA5);
        check("post_rst_reg3", 32'(src2_data), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        // ZERO_REG instance: reg0 writes are discarded, never forwarded.
        @(negedge clk);
        z_we = 1; z_dest = 2'd0; z_wdata = 8'hAA; z_src1 = 2'd0; z_src2 = 2'd1;
        #1;
        check("z_pre_reg0", 32'(z_rd1), 32'h0);
        @(negedge clk);
        z_we = 1; z_dest = 2'd1; z_wdata = 8'hBB; z_src1 = 2'd0; z_src2 = 2'd2;
        #1;
        check("z_reg0_after_write", 32'(z_rd1), 32'h0);
        @(negedge clk);
        z_we = 0; z_src1 = 2'd0; z_src2 = 2'd1;
        #1;
        check("z_reg0", 32'(z_rd1), 32'h0);
        check("z_reg1", 32'(z_rd2), 32'hBB);

        // Wide instance: 16-bit data, 8 registers.
        @(negedge clk);
        w_we = 1; w_dest = 3'd7; w_wdata = 16'hBEEF; w_src1 = 3'd7; w_src2 = 3'd0;
        @(negedge clk);
        w_we = 0; w_clr = 1;
        #1;
        check("w_reg7_pre", 32'(w_rd1), 32'hBEEF);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            w_clr = 0;
            #1;
            if (w_busy) busy_cnt++;
            if (w_done) done_cnt++;
        end
        check("w_busy_cycles", 32'(busy_cnt), 32'd8);
        check("w_done_pulses", 32'(done_cnt), 32'd1);
        check("w_reg7_post", 32'(w_rd1), 32'h0);
        check("w_busy_end", 32'(w_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
